// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU widths and decode control bit map
package cpu_pkg;
  localparam int DATA_W_DFLT = 32;
  localparam int ADDR_W_DFLT = 5;
  localparam int CTRL_W_DFLT = 8;

  localparam int REGWRITE   = 0;
  localparam int MEMTOREG   = 1;
  localparam int MEMWRITE   = 2;
  localparam int ALUSRC     = 3;
  localparam int REGDST     = 4;
  localparam int ALUCTL_LSB = 5;
  localparam int ALUCTL_MSB = 7;

  localparam logic [CTRL_W_DFLT-1:0] CTRL_NOP = '0;
endpackage

// File: rtl/wb_bypass.sv
// rtl/wb_bypass.sv - same-cycle writeback bypass for one register read port
module wb_bypass #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] rs,
  input  logic [DATA_W-1:0] rd,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] op
);
  // The bank writes on the edge, so its read port still shows the old value this cycle.
  logic hit;
  assign hit = reg_write && (write_reg == rs) && (rs != '0);
  assign op  = hit ? result : rd;
endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with writeback bypass,
// load-use stall detection and flush
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DFLT,
  parameter int ADDR_W = ADDR_W_DFLT,
  parameter int CTRL_W = CTRL_W_DFLT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              FlushE,
  input  logic [DATA_W-1:0] RD1D,
  input  logic [DATA_W-1:0] RD2D,
  input  logic [ADDR_W-1:0] RsD,
  input  logic [ADDR_W-1:0] RtD,
  input  logic [ADDR_W-1:0] RdD,
  input  logic [DATA_W-1:0] SignImmD,
  input  logic [CTRL_W-1:0] CtrlD,
  input  logic              RegWriteW,
  input  logic [ADDR_W-1:0] WriteRegW,
  input  logic [DATA_W-1:0] ResultW,
  output logic [DATA_W-1:0] RD1E,
  output logic [DATA_W-1:0] RD2E,
  output logic [ADDR_W-1:0] RsE,
  output logic [ADDR_W-1:0] RtE,
  output logic [ADDR_W-1:0] RdE,
  output logic [DATA_W-1:0] SignImmE,
  output logic [CTRL_W-1:0] CtrlE,
  output logic              ValidE,
  output logic              StallF,
  output logic              StallD
);
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              lwstall;
  logic              bubble;

  wb_bypass #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_byp_a (
    .rs        (RsD),
    .rd        (RD1D),
    .reg_write (RegWriteW),
    .write_reg (WriteRegW),
    .result    (ResultW),
    .op        (op_a)
  );

  wb_bypass #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_byp_b (
    .rs        (RtD),
    .rd        (RD2D),
    .reg_write (RegWriteW),
    .write_reg (WriteRegW),
    .result    (ResultW),
    .op        (op_b)
  );

  // A load in EX cannot forward its data in time for a consumer sitting in D.
  assign lwstall = CtrlE[MEMTOREG] && (RtE != '0) && ((RtE == RsD) || (RtE == RtD));
  assign StallF  = lwstall;
  assign StallD  = lwstall;
  assign bubble  = FlushE || lwstall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RD1E     <= '0;
      RD2E     <= '0;
      RsE      <= '0;
      RtE      <= '0;
      RdE      <= '0;
      SignImmE <= '0;
      CtrlE    <= CTRL_W'(CTRL_NOP);
      ValidE   <= 1'b0;
    end else begin
      // Operand/address fields load even for a bubble; zero control makes them inert.
      RD1E     <= op_a;
      RD2E     <= op_b;
      RsE      <= RsD;
      RtE      <= RtD;
      RdE      <= RdD;
      SignImmE <= SignImmD;
      if (bubble) begin
        CtrlE  <= CTRL_W'(CTRL_NOP);
        ValidE <= 1'b0;
      end else begin
        CtrlE  <= CtrlD;
        ValidE <= 1'b1;
      end
    end
  end
endmodule
